// File: rtl/seg_disp_pkg.sv
// Shared constants for the 7-segment display blocks.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg_disp_pkg;

    localparam int DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF    = 4'b1111;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern {g..a}.
module seg7_hex_decode
    import seg_disp_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (hex_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scroll_driver.sv
// Scrolls a circular hex message across four multiplexed common-anode digits,
// stepping the window offset once per rising edge of the slow countclk.
module seg_scroll_driver #(
    parameter int MSG_LEN = 16,
    parameter int DIGITS  = 4,
    parameter int SCAN_W  = 16,
    localparam int OFF_W  = $clog2(MSG_LEN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 countclk,
    input  logic                 en,
    input  logic                 dir,
    input  logic [MSG_LEN*4-1:0] msg,
    output logic [DIGITS-1:0]    an,
    output logic [6:0]           seg,
    output logic [OFF_W-1:0]     offset
);
    import seg_disp_pkg::*;

    localparam logic [DIGITS-1:0] AN_LEFT  = {1'b1, {(DIGITS-1){1'b0}}};
    localparam logic [OFF_W-1:0]  OFF_LAST = OFF_W'(MSG_LEN - 1);
    localparam logic [OFF_W:0]    LEN_EXT  = (OFF_W+1)'(MSG_LEN);

    logic                 cc_q,     cc_d;
    logic [OFF_W-1:0]     offset_q, offset_d;
    logic [SCAN_W-1:0]    scan_q,   scan_d;
    logic [DIGITS-1:0]    an_q,     an_d;
    logic [6:0]           seg_q,    seg_d;

    logic                 rise;
    logic [1:0]           digit_k;
    logic [OFF_W:0]       char_sum;
    logic [OFF_W-1:0]     char_idx;
    logic [3:0]           char_sel;
    logic [6:0]           seg_dec;

    assign rise    = countclk & ~cc_q;
    assign digit_k = scan_q[SCAN_W-1 -: 2];

    // Explicit wrap keeps the window correct for non-power-of-2 lengths.
    always_comb begin
        char_sum = {1'b0, offset_q} + {{(OFF_W-1){1'b0}}, digit_k};
        char_idx = char_sum[OFF_W-1:0];
        if (char_sum >= LEN_EXT) begin
            char_idx = OFF_W'(char_sum - LEN_EXT);
        end
        char_sel = msg[4*char_idx +: 4];
    end

    seg7_hex_decode u_dec (
        .hex_i (char_sel),
        .seg_o (seg_dec)
    );

    always_comb begin
        cc_d     = countclk;
        scan_d   = scan_q + 1'b1;
        offset_d = offset_q;
        if (rise && en) begin
            if (!dir) begin
                offset_d = (offset_q == OFF_LAST) ? '0 : offset_q + 1'b1;
            end else begin
                offset_d = (offset_q == '0) ? OFF_LAST : offset_q - 1'b1;
            end
        end
        an_d  = ~(AN_LEFT >> digit_k);
        seg_d = seg_dec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc_q     <= 1'b1;
            offset_q <= '0;
            scan_q   <= '0;
            an_q     <= AN_OFF[DIGITS-1:0];
            seg_q    <= SEG_BLANK;
        end else begin
            cc_q     <= cc_d;
            offset_q <= offset_d;
            scan_q   <= scan_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign an     = an_q;
    assign seg    = seg_q;
    assign offset = offset_q;

endmodule

// File: tb/tb_seg_scroll_driver.sv
// Self-checking bench for seg_scroll_driver with MSG_LEN=16, SCAN_W=4.
module tb_seg_scroll_driver;

    localparam int MSG_LEN = 16;
    localparam int SCAN_W  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        countclk = 1'b0;
    logic        en = 1'b0;
    logic        dir = 1'b0;
    logic [63:0] msg = 64'hFEDCBA9876543210;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [3:0]  offset;

    int n_vec = 0;
    int n_err = 0;

    // Reference state
    int         m_off;
    int         m_scan;
    bit         m_cc;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;

    seg_scroll_driver #(.MSG_LEN(MSG_LEN), .DIGITS(4), .SCAN_W(SCAN_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .countclk (countclk),
        .en       (en),
        .dir      (dir),
        .msg      (msg),
        .an       (an),
        .seg      (seg),
        .offset   (offset)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex7(input int v);
        case (v)
            0:  return 7'b1000000;  1:  return 7'b1111001;
            2:  return 7'b0100100;  3:  return 7'b0110000;
            4:  return 7'b0011001;  5:  return 7'b0010010;
            6:  return 7'b0000010;  7:  return 7'b1111000;
            8:  return 7'b0000000;  9:  return 7'b0010000;
            10: return 7'b0001000;  11: return 7'b0000011;
            12: return 7'b1000110;  13: return 7'b0100001;
            14: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // Behavioural model: displayed digit = scan/4, character = (offset+digit) mod 16.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_off   = 0;
            m_scan  = 0;
            m_cc    = 1'b1;
            exp_an  = 4'b1111;
            exp_seg = 7'b1111111;
        end else begin
            int k, c, ch;
            k  = m_scan / 4;
            c  = (m_off + k) % MSG_LEN;
            ch = int'((msg >> (4*c)) & 64'hF);
            exp_an  = 4'b1111;
            exp_an[3-k] = 1'b0;
            exp_seg = hex7(ch);
            if (countclk && !m_cc && en)
                m_off = dir ? (m_off + MSG_LEN - 1) % MSG_LEN : (m_off + 1) % MSG_LEN;
            m_cc   = countclk;
            m_scan = (m_scan + 1) % 16;
        end
    end

    task automatic cyc_check(input string name);
        @(negedge clk);
        n_vec++;
        if (offset !== 4'(m_off)) begin
            n_err++;
            $display("FAIL %s offset: got %0d want %0d", name, offset, m_off);
        end
        n_vec++;
        if (an !== exp_an || seg !== exp_seg) begin
            n_err++;
            $display("FAIL %s display: got an=%b seg=%b want an=%b seg=%b",
                     name, an, seg, exp_an, exp_seg);
        end
    endtask

    task automatic pulse(input string name);
        countclk = 1'b1;
        cyc_check(name);
        countclk = 1'b0;
        cyc_check(name);
    endtask

    task automatic test_reset;
        countclk = 1'b1;
        rst = 1'b1;
        #12;
        n_vec++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || offset !== 4'd0) begin
            n_err++;
            $display("FAIL reset_vals: got an=%b seg=%b off=%0d want 1111 1111111 0", an, seg, offset);
        end
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc_check("reset_hold_high");
            n_vec++;
            if (offset !== 4'd0) begin
                n_err++;
                $display("FAIL reset_no_adv: got %0d want 0", offset);
            end
        end
    endtask

    task automatic test_single_advance;
        msg = 64'hFEDCBA9876543210;
        en = 1'b1;
        dir = 1'b0;
        countclk = 1'b0;
        cyc_check("adv_low");
        cyc_check("adv_low");
        countclk = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc_check("adv_high");
            n_vec++;
            if (offset !== 4'd1) begin
                n_err++;
                $display("FAIL adv_once: cycle %0d got %0d want 1", i, offset);
            end
        end
        countclk = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc_check("adv_fall");
            n_vec++;
            if (offset !== 4'd1) begin
                n_err++;
                $display("FAIL adv_fall: got %0d want 1", offset);
            end
        end
    endtask

    task automatic test_wrap;
        dir = 1'b0;
        for (int i = 0; i < 14; i++) pulse("wrap_setup");
        n_vec++;
        if (offset !== 4'd15) begin
            n_err++;
            $display("FAIL wrap_at15: got %0d want 15", offset);
        end
        pulse("wrap_first");
        n_vec++;
        if (offset !== 4'd0) begin
            n_err++;
            $display("FAIL wrap_15_to_0: got %0d want 0", offset);
        end
        for (int i = 0; i < 15; i++) pulse("wrap_loop");
        for (int i = 0; i < 1; i++) pulse("wrap_loop");
        dir = 1'b1;
        n_vec++;
        if (offset !== 4'd0) begin
            n_err++;
            $display("FAIL wrap_full_loop: got %0d want 0", offset);
        end
        pulse("wrap_right");
        n_vec++;
        if (offset !== 4'd15) begin
            n_err++;
            $display("FAIL wrap_0_to_15: got %0d want 15", offset);
        end
    endtask

    task automatic test_enable_freeze;
        int held;
        held = m_off;
        en = 1'b0;
        for (int i = 0; i < 3; i++) pulse("freeze");
        countclk = 1'b1;
        cyc_check("freeze_high");
        en = 1'b1;
        for (int i = 0; i < 4; i++) cyc_check("reenable_high");
        n_vec++;
        if (offset !== 4'(held)) begin
            n_err++;
            $display("FAIL freeze_hold: got %0d want %0d", offset, held);
        end
        countclk = 1'b0;
        cyc_check("reenable_low");
        pulse("reenable_step");
        n_vec++;
        if (offset !== 4'((held + MSG_LEN - 1) % MSG_LEN)) begin
            n_err++;
            $display("FAIL reenable_step: got %0d want %0d", offset, (held + MSG_LEN - 1) % MSG_LEN);
        end
    endtask

    task automatic test_scan_window;
        logic [3:0] an_seq [4];
        logic [6:0] seg_seq [4];
        an_seq  = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
        seg_seq = '{7'b0000110, 7'b0001110, 7'b1000000, 7'b1111001};
        msg = 64'hFEDCBA9876543210;
        en = 1'b1;
        dir = 1'b0;
        for (int i = 0; i < 32 && m_off != 14; i++) pulse("scan_setup");
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc_check("scan_window");
            // Output reflects the scan value of the previous cycle.
            if (((m_scan + 15) % 16) % 4 == 0 || i == 19) begin
                int k;
                k = ((m_scan + 15) % 16) / 4;
                n_vec++;
                if (an !== an_seq[k] || seg !== seg_seq[k]) begin
                    n_err++;
                    $display("FAIL scan_digit%0d: got an=%b seg=%b want an=%b seg=%b",
                             k, an, seg, an_seq[k], seg_seq[k]);
                end
            end
        end
        en = 1'b1;
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            en       = 1'($urandom_range(0, 3) != 0);
            dir      = 1'($urandom);
            countclk = 1'($urandom);
            if ($urandom_range(0, 15) == 0) msg = {$urandom, $urandom};
            cyc_check("random");
        end
        countclk = 1'b0;
        cyc_check("random_end");
    endtask

    task automatic test_async_reset;
        en = 1'b1;
        dir = 1'b0;
        for (int i = 0; i < 32 && m_off != 7; i++) pulse("areset_setup");
        n_vec++;
        if (offset !== 4'd7) begin
            n_err++;
            $display("FAIL areset_setup: got %0d want 7", offset);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (offset !== 4'd0 || an !== 4'b1111 || seg !== 7'b1111111) begin
            n_err++;
            $display("FAIL async_reset: got off=%0d an=%b seg=%b want 0 1111 1111111", offset, an, seg);
        end
        @(negedge clk);
        rst = 1'b0;
        cyc_check("after_reset");
        n_vec++;
        if (an !== 4'b0111) begin
            n_err++;
            $display("FAIL restart_digit0: got %b want 0111", an);
        end
        for (int i = 0; i < 6; i++) cyc_check("after_reset");
    endtask

    initial begin
        test_reset();
        test_single_advance();
        test_wrap();
        test_enable_freeze();
        test_scan_window();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
